multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multicycle control FSM sitting directly downstream of the instruction-fetch stage. It gates fetch, latches the fetched 32-bit instruction, and decodes it. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables. It also drives the 2-bit `pc_src` selector consumed by fetch on its next FETCH cycle.

## Interface
Parameters:
- `RESET_STATE`, 3'd0: state code entered on reset (FETCH); must stay 0.

Ports:
- `clock`, input, 1: single system clock, all state updates on posedge.
- `reset`, input, 1: asynchronous, active-high; forces FETCH and output reset values immediately.
- `instruction`, input, 32: word from fetch; valid in the cycle after `fetch_en`=1.
- `z`, input, 1: ALU zero flag, valid in EXEC.
- `fetch_en`, output, 1: fetch may advance PC this cycle.
- `pc_src`, output, 2: 00 sequential, 10 jump/branch-taken, 11 return (`jar`); 01 never driven.
- `ir`, output, 32: latched instruction.
- `reg_write`, output, 1: register-file write strobe.
- `mem_read`, output, 1: data-memory read strobe.
- `mem_write`, output, 1: data-memory write strobe.
- `alu_op`, output, 3: 000 AND, 001 ADD, 010 SUB, 011 SLL, 100 SRL.
- `alu_src`, output, 1: 1 selects immediate or shift amount as ALU operand B.
- `wb_src`, output, 2: 00 ALU, 01 memory, 10 `next_pc`.
- `push`, output, 1: push `next_pc` onto return stack.
- `pop`, output, 1: pop return stack.
- `illegal`, output, 1: sticky flag for undefined function/type combination.
- `state`, output, 3: current state, for debug.

## Operation
- Instruction fields:
  - `func`=[31:27], `rs1`=[26:22], `rd`=[21:17], `rs2`=[16:12].
  - `imm14`=[16:3]; `sa`=[11:7]; J-type offset=[26:3].
  - `type`=[2:1]: 00 R, 01 I, 10 J, 11 S.
  - `stop`=[0].
- Defined opcodes:
  - R: `func` 0 AND, 1 ADD, 2 SUB.
  - I: 0 ANDI, 1 ADDI, 2 LW, 3 SW, 4 BEQ.
  - J: 0 J, 1 JAL.
  - S: 0 SLL, 1 SRL, 2 SLLV, 3 SRLV.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Sequences:
  - ALU ops (R, S, ANDI, ADDI): F→D→E→W→F.
  - LW: F→D→E→M→W→F.
  - SW: F→D→E→M→F.
  - BEQ: F→D→E→F.
  - J, JAL: F→D→F.
- FETCH: `fetch_en`=1; `pc_src` presents the redirect recorded by the previous instruction; go to DECODE.
- DECODE: `ir`<=`instruction` at the end of the cycle; decode uses the live `instruction` in this cycle, `ir` afterwards.
  - J: record `pc_src`=10.
  - JAL: record `pc_src`=10 and assert `push`=1 for this cycle.
- EXEC: `alu_op`/`alu_src` from decode; `alu_src`=1 for ANDI/ADDI/LW/SW/SLL/SRL.
  - BEQ: `alu_op`=SUB; record 10 if `z`=1, else 00.
- MEM: LW asserts `mem_read`=1; SW asserts `mem_write`=1.
- WB: `reg_write`=1; `wb_src`=01 for LW, else 00.
- Stop bit: on R/S/ANDI/ADDI/LW/SW with `stop`=1, record `pc_src`=11 and assert `pop`=1 in the final state. `stop` is ignored on BEQ and J-type.
- Illegal combination: set `illegal`; treat the instruction as a NOP (F→D→F, `pc_src`=00, no strobes). `illegal` clears only on reset.

## Timing
- Reset values:
  - `state`=FETCH, `fetch_en`=1 (combinational from state), `pc_src`=00, `ir`=0.
  - All strobes 0, `alu_op`=000, `alu_src`=0, `wb_src`=00, `illegal`=0.
- Strobes, `alu_*` and `wb_src` are Moore outputs decoded from `state` and `ir`/`instruction`; they are glitch-free within a state.
- `pc_src` is registered: written on the edge leaving an instruction's final state, held through FETCH, cleared to 00 on the edge leaving FETCH.
- `push`/`pop` are single-cycle pulses; never both 1.
- Instruction latency in cycles: ALU 4, LW 5, SW 4, BEQ 3, J/JAL 2.
- Reset asserted mid-instruction: abort at once, no pending strobe survives, recorded `pc_src` discarded; resume at FETCH on the first edge after deassert.

## Test plan
- Reset mid-MEM of an LW: `mem_read` drops to 0 immediately; after release `state`=0, `pc_src`=00, `fetch_en`=1.
- ADDI `0x0842002A` → states 0,1,2,4,0; `alu_op`=001 and `alu_src`=1 in EXEC; `reg_write`=1 only in WB; `pc_src`=00.
- LW `0x10D4003A` → 5-cycle sequence; `mem_read` in MEM, `wb_src`=01 with `reg_write` in WB; SW `0x184C001A` → `mem_write` in MEM, no WB.
- BEQ `0x21940042` run twice: with `z`=1 → `pc_src`=10 during the next FETCH; with `z`=0 → 00; 3 cycles each.
- JAL `0x08000064` → 2 cycles, `push` pulse in DECODE, `pc_src`=10 in FETCH. Then ADD-with-stop `0x08446001` → `pop` pulse in WB, `pc_src`=11 in the following FETCH.
- R-type with `func`=7 → `illegal`=1 and sticky; no strobes; next instruction runs normally.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer that gates fetch,
// latches and decodes the fetched instruction, drives the datapath strobes and
// records the pc_src redirect that fetch consumes on the next FETCH cycle.
module multicycle_control_unit #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        z,
    output logic        fetch_en,
    output logic [1:0]  pc_src,
    output logic [31:0] ir,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic [1:0]  wb_src,
    output logic        push,
    output logic        pop,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Instruction classes that share one state sequence; K_NOP covers illegal encodings.
    typedef enum logic [2:0] {
        K_NOP = 3'd0,
        K_ALU = 3'd1,
        K_LW  = 3'd2,
        K_SW  = 3'd3,
        K_BEQ = 3'd4,
        K_J   = 3'd5,
        K_JAL = 3'd6
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       stop;
    } dec_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b10;
    localparam logic [1:0] PC_RET  = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;

    // Decode only the fields that steer control: func, type and stop.
    function automatic dec_t decode_instr(input logic [4:0] func,
                                          input logic [1:0] typ,
                                          input logic       stop);
        dec_t d;
        d = '{kind: K_NOP, alu_op: ALU_AND, alu_src: 1'b0, stop: 1'b0};
        case (typ)
            2'b00: begin // R-type
                case (func)
                    5'd0:    begin d.kind = K_ALU; d.alu_op = ALU_AND; end
                    5'd1:    begin d.kind = K_ALU; d.alu_op = ALU_ADD; end
                    5'd2:    begin d.kind = K_ALU; d.alu_op = ALU_SUB; end
                    default: d.kind = K_NOP;
                endcase
            end
            2'b01: begin // I-type
                case (func)
                    5'd0:    begin d.kind = K_ALU; d.alu_op = ALU_AND; d.alu_src = 1'b1; end
                    5'd1:    begin d.kind = K_ALU; d.alu_op = ALU_ADD; d.alu_src = 1'b1; end
                    5'd2:    begin d.kind = K_LW;  d.alu_op = ALU_ADD; d.alu_src = 1'b1; end
                    5'd3:    begin d.kind = K_SW;  d.alu_op = ALU_ADD; d.alu_src = 1'b1; end
                    5'd4:    begin d.kind = K_BEQ; d.alu_op = ALU_SUB; end
                    default: d.kind = K_NOP;
                endcase
            end
            2'b10: begin // J-type
                case (func)
                    5'd0:    d.kind = K_J;
                    5'd1:    d.kind = K_JAL;
                    default: d.kind = K_NOP;
                endcase
            end
            default: begin // S-type: shift-by-sa uses the immediate path, *V forms use rs2
                case (func)
                    5'd0:    begin d.kind = K_ALU; d.alu_op = ALU_SLL; d.alu_src = 1'b1; end
                    5'd1:    begin d.kind = K_ALU; d.alu_op = ALU_SRL; d.alu_src = 1'b1; end
                    5'd2:    begin d.kind = K_ALU; d.alu_op = ALU_SLL; end
                    5'd3:    begin d.kind = K_ALU; d.alu_op = ALU_SRL; end
                    default: d.kind = K_NOP;
                endcase
            end
        endcase
        // stop only has meaning for instructions that end in a sequential PC
        if (d.kind inside {K_ALU, K_LW, K_SW}) begin
            d.stop = stop;
        end
        return d;
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_pc_src;
    logic [1:0] w_pc_src_next;
    logic [31:0] r_ir;
    logic       r_illegal;
    dec_t       w_dec_live;
    dec_t       w_dec_ir;
    dec_t       w_dec;

    // DECODE sees the instruction the cycle it arrives; later states use the latched copy.
    assign w_dec_live = decode_instr(instruction[31:27], instruction[2:1], instruction[0]);
    assign w_dec_ir   = decode_instr(r_ir[31:27], r_ir[2:1], r_ir[0]);
    assign w_dec      = (r_state == S_DECODE) ? w_dec_live : w_dec_ir;

    // State register; reset takes effect immediately so no strobe outlives it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Redirect register: written when an instruction retires, cleared as FETCH is left.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc_src <= PC_SEQ;
        end else begin
            r_pc_src <= w_pc_src_next;
        end
    end

    // Instruction latch and sticky illegal flag, both updated at the end of DECODE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir      <= '0;
            r_illegal <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_ir <= instruction;
            if (w_dec_live.kind == K_NOP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state, redirect and Moore strobe decode from state and decoded instruction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next_state  = S_FETCH;
        w_pc_src_next = r_pc_src;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_op        = ALU_AND;
        alu_src       = 1'b0;
        wb_src        = WB_ALU;
        push          = 1'b0;
        pop           = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next_state  = S_DECODE;
                w_pc_src_next = PC_SEQ;
            end
            S_DECODE: begin
                case (w_dec.kind)
                    K_NOP: begin
                        w_next_state  = S_FETCH;
                        w_pc_src_next = PC_SEQ;
                    end
                    K_J: begin
                        w_next_state  = S_FETCH;
                        w_pc_src_next = PC_JUMP;
                    end
                    K_JAL: begin
                        w_next_state  = S_FETCH;
                        w_pc_src_next = PC_JUMP;
                        push          = 1'b1;
                    end
                    default: w_next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_op  = w_dec.alu_op;
                alu_src = w_dec.alu_src;
                case (w_dec.kind)
                    K_BEQ: begin
                        w_next_state  = S_FETCH;
                        w_pc_src_next = z ? PC_JUMP : PC_SEQ;
                    end
                    K_LW, K_SW: w_next_state = S_MEM;
                    K_ALU:      w_next_state = S_WB;
                    default:    w_next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                case (w_dec.kind)
                    K_LW: begin
                        mem_read     = 1'b1;
                        w_next_state = S_WB;
                    end
                    K_SW: begin
                        mem_write     = 1'b1;
                        w_next_state  = S_FETCH;
                        w_pc_src_next = w_dec.stop ? PC_RET : PC_SEQ;
                        pop           = w_dec.stop;
                    end
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_WB: begin
                reg_write     = 1'b1;
                wb_src        = (w_dec.kind == K_LW) ? WB_MEM : WB_ALU;
                w_next_state  = S_FETCH;
                w_pc_src_next = w_dec.stop ? PC_RET : PC_SEQ;
                pop           = w_dec.stop;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    assign fetch_en = (r_state == S_FETCH);
    assign pc_src   = r_pc_src;
    assign ir       = r_ir;
    assign illegal  = r_illegal;
    assign state    = r_state;

endmodule
